// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: reset words, default NOP and
// fetch FSM state encodings.
package if_fetch_unit_pkg;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_unit_skid_buffer.sv
// One-entry holding register for an instruction returned while decode is stalled.
module if_fetch_unit_skid_buffer
  import if_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] d_inst,
  input  logic [31:0] d_pc,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] pc
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      inst  <= ZERO_WORD;
      pc    <= ZERO_WORD;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= d_inst;
      pc    <= d_pc;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: turns pc/chip_enable into imem req/ack transactions and fills the
// IF/ID register, with a skid entry for decode stalls and wrong-path squashing.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int          ACK_TIMEOUT = 255,
  parameter logic [31:0] NOP_INST    = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        chip_enable,
  input  logic        branch_flag,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        pc_stall,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        fetch_err,
  output logic [1:0]  state_dbg
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);

  fetch_state_t  state;
  logic [CW-1:0] cnt;
  logic [31:0]   req_addr;

  logic        misaligned;
  logic        fetch_live;
  logic        misaligned_fetch;
  logic        mem_ack;
  logic        timeout_hit;
  logic        eff_ack;
  logic        accept;
  logic        wait_cyc;
  logic [31:0] eff_data;

  logic        skid_load;
  logic        skid_clear;
  logic        skid_valid;
  logic [31:0] skid_inst;
  logic [31:0] skid_pc;

  // A request that has already waited a cycle must complete even if chip_enable drops.
  assign misaligned       = is_misaligned(pc);
  assign fetch_live       = chip_enable | (cnt != '0);
  assign misaligned_fetch = (state == ST_REQ) & fetch_live & misaligned;

  assign imem_req  = ((state == ST_REQ) & fetch_live & ~misaligned) | (state == ST_DROP);
  assign imem_addr = (state == ST_DROP) ? req_addr : pc;

  assign mem_ack     = imem_req & imem_ack;
  assign timeout_hit = imem_req & ~imem_ack & (cnt == TO_LAST);
  assign eff_ack     = mem_ack | misaligned_fetch | timeout_hit;
  assign eff_data    = mem_ack ? imem_rdata : NOP_INST;
  assign accept      = eff_ack & ~id_stall;
  assign wait_cyc    = imem_req & ~imem_ack & ~timeout_hit;

  assign state_dbg = state;

  always_comb begin
    pc_stall = 1'b0;
    case (state)
      ST_REQ:  pc_stall = fetch_live & ~branch_flag & ~accept;
      ST_HOLD: pc_stall = ~branch_flag & id_stall;
      ST_DROP: pc_stall = 1'b1;
      default: pc_stall = 1'b0;
    endcase
  end

  assign skid_load  = (state == ST_REQ) & fetch_live & chip_enable & ~branch_flag
                    & eff_ack & id_stall;
  assign skid_clear = (state == ST_HOLD) & (branch_flag | ~id_stall);

  if_fetch_unit_skid_buffer u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .clear  (skid_clear),
    .d_inst (eff_data),
    .d_pc   (pc),
    .valid  (skid_valid),
    .inst   (skid_inst),
    .pc     (skid_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      if_inst   <= NOP_INST;
      if_pc     <= ZERO_WORD;
      if_valid  <= 1'b0;
      fetch_err <= 1'b0;
      cnt       <= '0;
      req_addr  <= ZERO_WORD;
    end else begin
      if (timeout_hit || misaligned_fetch) fetch_err <= 1'b1;

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!id_stall) if_valid <= 1'b0;
          if (chip_enable) state <= ST_REQ;
        end

        ST_REQ: begin
          req_addr <= pc;
          cnt      <= wait_cyc ? cnt + 1'b1 : '0;
          if (!fetch_live) begin
            state <= ST_IDLE;
            if (!id_stall) if_valid <= 1'b0;
          end else if (branch_flag) begin
            // Wrong-path fetch: an unanswered request is drained in DROP.
            if_valid <= 1'b0;
            cnt      <= '0;
            if (!eff_ack)         state <= ST_DROP;
            else if (!chip_enable) state <= ST_IDLE;
          end else if (eff_ack && !chip_enable) begin
            state <= ST_IDLE;
            if (!id_stall) if_valid <= 1'b0;
          end else if (accept) begin
            if_inst  <= eff_data;
            if_pc    <= pc;
            if_valid <= 1'b1;
          end else if (eff_ack) begin
            state <= ST_HOLD;
          end else if (!id_stall) begin
            if_valid <= 1'b0;
          end
        end

        ST_HOLD: begin
          cnt <= '0;
          if (branch_flag) begin
            if_valid <= 1'b0;
            state    <= chip_enable ? ST_REQ : ST_IDLE;
          end else if (!id_stall) begin
            if_inst  <= skid_inst;
            if_pc    <= skid_pc;
            if_valid <= skid_valid;
            state    <= chip_enable ? ST_REQ : ST_IDLE;
          end
        end

        ST_DROP: begin
          cnt <= wait_cyc ? cnt + 1'b1 : '0;
          if (mem_ack || timeout_hit) begin
            cnt   <= '0;
            state <= chip_enable ? ST_REQ : ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
